// File: rtl/block_mem_responder.sv
// block_mem_responder
//   Fixed-latency block memory that answers cache block fetches and
//   write-backs. Each stored block is four DATA_WIDTH words; there are
//   2**IDX_BITS blocks, indexed by req_addr[IDX_BITS+3:4] (addresses wrap).
//   One request is handled at a time: IDLE -> WAIT (LATENCY cycles) -> RESP.
//
// Ports
//   clk, rst_n             : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    : request handshake; ready only in IDLE
//   req_we                 : 1 = block write-back, 0 = block fetch
//   req_addr               : byte address of the block
//   req_wdata              : write-back block, word 0 in the low bits
//   resp_valid/resp_ready  : response handshake, held until accepted
//   resp_rdata             : fetched block, or echo of the written block
//   resp_we                : req_we of the request being answered
//   busy                   : high whenever the FSM is not IDLE
module block_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 10,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [4*DATA_WIDTH-1:0] resp_rdata,
  output logic                    resp_we,
  output logic                    busy
);

  localparam int BLK_W = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [IDX_BITS-1:0] r_idx;
  logic [BLK_W-1:0]  r_wdata;
  logic              r_resp_valid;
  logic [BLK_W-1:0]  r_resp_rdata;
  logic              r_resp_we;
  logic [BLK_W-1:0]  r_mem [2**IDX_BITS];

  logic [IDX_BITS-1:0] w_idx;
  logic                w_commit;
  logic                w_unused_addr;

  assign w_idx = req_addr[IDX_BITS+3:4];
  // Offset and high address bits are intentionally dropped.
  assign w_unused_addr = ^{req_addr[3:0], req_addr[DATA_WIDTH-1:IDX_BITS+4]};

  // Last WAIT cycle: the edge that moves to RESP and commits a write.
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_we    = r_resp_we;

  // Storage is never reset. Reset forces the FSM out of WAIT
  // asynchronously, so an aborted write never reaches this port.
  always_ff @(posedge clk) begin
    if (w_commit && r_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state <= WAIT;
            r_cnt   <= 4'(LATENCY - 1);
            r_we    <= req_we;
            r_idx   <= w_idx;
            r_wdata <= req_wdata;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_we    <= r_we;
            // Writes echo the captured block, so a following read of the
            // same index sees the committed data without any bypass.
            r_resp_rdata <= r_we ? r_wdata : r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // resp_rdata and resp_we keep their values after the handshake.
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_responder.sv
module tb_block_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic         d4_req_valid, d4_req_ready, d4_req_we;
  logic [31:0]  d4_req_addr;
  logic [127:0] d4_req_wdata;
  logic         d4_resp_valid, d4_resp_ready, d4_resp_we, d4_busy;
  logic [127:0] d4_resp_rdata;

  // LATENCY=1 instance
  logic         d1_req_valid, d1_req_ready, d1_req_we;
  logic [31:0]  d1_req_addr;
  logic [127:0] d1_req_wdata;
  logic         d1_resp_valid, d1_resp_ready, d1_resp_we, d1_busy;
  logic [127:0] d1_resp_rdata;

  block_mem_responder #(.DATA_WIDTH(32), .IDX_BITS(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready), .req_we(d4_req_we),
    .req_addr(d4_req_addr), .req_wdata(d4_req_wdata),
    .resp_valid(d4_resp_valid), .resp_ready(d4_resp_ready),
    .resp_rdata(d4_resp_rdata), .resp_we(d4_resp_we), .busy(d4_busy)
  );

  block_mem_responder #(.DATA_WIDTH(32), .IDX_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_we(d1_req_we),
    .req_addr(d1_req_addr), .req_wdata(d1_req_wdata),
    .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready),
    .resp_rdata(d1_resp_rdata), .resp_we(d1_resp_we), .busy(d1_busy)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         we;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] BLK_DB = {4{32'hDEADBEEF}};
  localparam logic [127:0] BLK_A  = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam logic [127:0] BLK_B  = 128'hBBBB_0004_BBBB_0003_BBBB_0002_BBBB_0001;
  localparam logic [127:0] BLK_C  = 128'hC0C0_1111_C0C0_2222_C0C0_3333_C0C0_4444;
  localparam logic [127:0] BLK_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] BLK_E  = 128'hEEEE_0000_1111_EEEE_2222_EEEE_3333_EEEE;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every response handshake.
  always @(negedge clk) begin
    if (rst_n && d4_resp_valid && d4_resp_ready) begin
      if (q4.size() == 0) begin
        check("resp4_unexpected", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("resp4_rdata", d4_resp_rdata, e.d);
        check("resp4_we", {127'd0, d4_resp_we}, {127'd0, e.we});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && d1_resp_valid && d1_resp_ready) begin
      if (q1.size() == 0) begin
        check("resp1_unexpected", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("resp1_rdata", d1_resp_rdata, e.d);
        check("resp1_we", {127'd0, d1_resp_we}, {127'd0, e.we});
      end
    end
  end

  // Issue one request on dut4 and return once resp_valid is seen (at #1
  // after the edge). Checks the accept-to-valid edge count.
  task automatic xact4(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp_d, input bit scramble);
    int n;
    @(negedge clk);
    d4_req_valid = 1'b1;
    d4_req_we    = we;
    d4_req_addr  = addr;
    d4_req_wdata = wd;
    q4.push_back('{exp_d, we});
    @(posedge clk);
    #1;
    d4_req_valid = 1'b0;
    n = 0;
    while (n < 20 && !d4_resp_valid) begin
      if (scramble) begin
        d4_req_we    = ~we;
        d4_req_addr  = $urandom;
        d4_req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("latency4", 128'(n), 128'd4);
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (n < 20 && !d4_req_ready) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle4_timeout", {127'd0, d4_req_ready}, 128'd1);
  endtask

  // LATENCY=1 transaction with resp_ready held high.
  task automatic xact1(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp_d);
    @(negedge clk);
    d1_req_valid = 1'b1;
    d1_req_we    = we;
    d1_req_addr  = addr;
    d1_req_wdata = wd;
    q1.push_back('{exp_d, we});
    @(posedge clk);
    #1;
    d1_req_valid = 1'b0;
    check("l1_wait_valid", {127'd0, d1_resp_valid}, 128'd0);
    @(posedge clk);
    #1;
    check("l1_resp_valid", {127'd0, d1_resp_valid}, 128'd1);
    check("l1_resp_ready_low", {127'd0, d1_req_ready}, 128'd0);
    @(posedge clk);
    #1;
    check("l1_valid_pulse", {127'd0, d1_resp_valid}, 128'd0);
    check("l1_ready_again", {127'd0, d1_req_ready}, 128'd1);
    check("l1_rdata_hold", d1_resp_rdata, exp_d);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_req_ready"}, {127'd0, d4_req_ready}, 128'd1);
    check({tag, "_resp_valid"}, {127'd0, d4_resp_valid}, 128'd0);
    check({tag, "_resp_rdata"}, d4_resp_rdata, 128'd0);
    check({tag, "_resp_we"}, {127'd0, d4_resp_we}, 128'd0);
    check({tag, "_busy"}, {127'd0, d4_busy}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    rst_n = 1'b0;
    d4_req_valid = 0; d4_req_we = 0; d4_req_addr = 0; d4_req_wdata = 0; d4_resp_ready = 1;
    d1_req_valid = 0; d1_req_we = 0; d1_req_addr = 0; d1_req_wdata = 0; d1_resp_ready = 1;
    #1;
    check_reset4("rst0");
    check("rst0_d1_ready", {127'd0, d1_req_ready}, 128'd1);
    check("rst0_d1_busy", {127'd0, d1_busy}, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write then read back, 4-cycle latency.
    xact4(1'b1, 32'h0000_0040, BLK_DB, BLK_DB, 1'b0);
    wait_idle4();
    xact4(1'b0, 32'h0000_0040, 128'd0, BLK_DB, 1'b0);
    wait_idle4();

    // Address wrap: bit 14 is above the index field.
    xact4(1'b1, 32'h0000_0010, BLK_D, BLK_D, 1'b0);
    wait_idle4();
    xact4(1'b0, 32'h0000_4010, 128'd0, BLK_D, 1'b0);
    wait_idle4();

    // Response stall: outputs hold, a new request is ignored.
    d4_resp_ready = 1'b0;
    xact4(1'b0, 32'h0000_0040, 128'd0, BLK_DB, 1'b0);
    held = d4_resp_rdata;
    check("stall_first_rdata", held, BLK_DB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d4_req_valid = 1'b1;
      d4_req_we    = 1'b1;
      d4_req_addr  = 32'h0000_0040;
      d4_req_wdata = 128'h5555;
      @(posedge clk);
      #1;
      check("stall_valid", {127'd0, d4_resp_valid}, 128'd1);
      check("stall_rdata", d4_resp_rdata, held);
      check("stall_req_ready", {127'd0, d4_req_ready}, 128'd0);
    end
    d4_req_valid  = 1'b0;
    d4_resp_ready = 1'b1;
    wait_idle4();
    xact4(1'b0, 32'h0000_0040, 128'd0, BLK_DB, 1'b0);
    wait_idle4();

    // Reset during WAIT aborts a write.
    xact4(1'b1, 32'h0000_0080, BLK_A, BLK_A, 1'b0);
    wait_idle4();
    @(negedge clk);
    d4_req_valid = 1'b1;
    d4_req_we    = 1'b1;
    d4_req_addr  = 32'h0000_0080;
    d4_req_wdata = BLK_B;
    @(posedge clk);
    #1;
    d4_req_valid = 1'b0;
    check("abort_busy", {127'd0, d4_busy}, 128'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset4("rstw");
    repeat (2) @(posedge clk);
    #1;
    check_reset4("rstw_hold");
    rst_n = 1'b1;
    xact4(1'b0, 32'h0000_0080, 128'd0, BLK_A, 1'b0);
    wait_idle4();

    // Request inputs scrambled during WAIT; captured values win.
    xact4(1'b1, 32'h0000_0100, BLK_C, BLK_C, 1'b1);
    wait_idle4();
    xact4(1'b0, 32'h0000_0100, 128'd0, BLK_C, 1'b1);
    wait_idle4();

    // LATENCY=1 instance.
    xact1(1'b1, 32'h0000_0020, BLK_E, BLK_E);
    xact1(1'b0, 32'h0000_0020, 128'd0, BLK_E);

    repeat (3) @(posedge clk);
    #1;
    check("q4_drained", 128'(q4.size()), 128'd0);
    check("q1_drained", 128'(q1.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
